// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID/EX stage.
//   - ALU control codes driven to the EX-stage ALU
//   - ALUOp codes produced by main control
//   - R-type funct codes understood by the ALU decoder
//   - ex_regs_t: the full set of fields held in the ID/EX register
package cpu_pkg;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADDI = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b0111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ADDI  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [3:0]  alu_ctrl;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } ex_regs_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle between ID, the forwarding sources and the ID/EX stage.
//   master: ID decode / EX-MEM / MEM-WB side (drives id_*, exm_*, wb_*)
//   slave : the ID/EX stage (drives ALU operands, control and hazard_o)
interface id_ex_stage_if;
    logic [31:0] id_rs_data_i;
    logic [31:0] id_rt_data_i;
    logic [31:0] id_imm_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic [4:0]  id_rd_i;
    logic [5:0]  id_funct_i;
    logic [1:0]  id_aluop_i;
    logic        id_alusrc_i;
    logic        id_regdst_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        id_memwrite_i;
    logic        id_memtoreg_i;

    logic        exm_regwrite_i;
    logic [4:0]  exm_rd_i;
    logic [31:0] exm_data_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;

    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] mem_wdata_o;
    logic [4:0]  wreg_o;
    logic        regwrite_o;
    logic        memread_o;
    logic        memwrite_o;
    logic        memtoreg_o;
    logic        hazard_o;

    modport master (
        output id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
               id_funct_i, id_aluop_i, id_alusrc_i, id_regdst_i, id_regwrite_i,
               id_memread_i, id_memwrite_i, id_memtoreg_i,
               exm_regwrite_i, exm_rd_i, exm_data_i,
               wb_regwrite_i, wb_rd_i, wb_data_i,
        input  data1_o, data2_o, alu_ctrl_o, mem_wdata_o, wreg_o,
               regwrite_o, memread_o, memwrite_o, memtoreg_o, hazard_o
    );

    modport slave (
        input  id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
               id_funct_i, id_aluop_i, id_alusrc_i, id_regdst_i, id_regwrite_i,
               id_memread_i, id_memwrite_i, id_memtoreg_i,
               exm_regwrite_i, exm_rd_i, exm_data_i,
               wb_regwrite_i, wb_rd_i, wb_data_i,
        output data1_o, data2_o, alu_ctrl_o, mem_wdata_o, wreg_o,
               regwrite_o, memread_o, memwrite_o, memtoreg_o, hazard_o
    );
endinterface

// File: rtl/id_ex_stage_alu_control.sv
// ALU control decoder, purely combinational.
//   aluop in 2 : main-control ALUOp
//   funct in 6 : R-type function field (only used for R-type)
//   ctrl  out 4: ALU control code
module alu_control
    import cpu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] ctrl
);

    always_comb begin
        ctrl = ALU_NONE;
        case (aluop)
            ALUOP_ADD:  ctrl = ALU_ADD;
            ALUOP_SUB:  ctrl = ALU_SUB;
            ALUOP_ADDI: ctrl = ALU_ADDI;
            default: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_MUL: ctrl = ALU_MUL;
                    default:   ctrl = ALU_NONE;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
//   clk_i   in : clock, rising edge
//   rst_i   in : synchronous active-high reset
//   stall_i in : freeze, holds all state (wins over flush)
//   flush_i in : load a bubble on the next edge
//   bus        : id_ex_stage_if.slave (ID fields, forwarding sources, EX outputs)
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    id_ex_stage_if.slave  bus
);

    ex_regs_t    ex_q;
    ex_regs_t    ex_d;
    logic [3:0]  alu_ctrl_d;
    logic        hazard;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    alu_control u_alu_control (
        .aluop (bus.id_aluop_i),
        .funct (bus.id_funct_i),
        .ctrl  (alu_ctrl_d)
    );

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = 1'b1;
        ex_d.rs_data  = bus.id_rs_data_i;
        ex_d.rt_data  = bus.id_rt_data_i;
        ex_d.imm      = bus.id_imm_i;
        ex_d.rs       = bus.id_rs_i;
        ex_d.rt       = bus.id_rt_i;
        ex_d.wreg     = bus.id_regdst_i ? bus.id_rd_i : bus.id_rt_i;
        ex_d.alu_ctrl = alu_ctrl_d;
        ex_d.alusrc   = bus.id_alusrc_i;
        ex_d.regwrite = bus.id_regwrite_i;
        ex_d.memread  = bus.id_memread_i;
        ex_d.memwrite = bus.id_memwrite_i;
        ex_d.memtoreg = bus.id_memtoreg_i;
    end

    // A load in EX whose target is read by the instruction now in ID.
    assign hazard = !rst_i && ex_q.valid && ex_q.memread && (ex_q.rt != 5'd0) &&
                    ((ex_q.rt == bus.id_rs_i) || (ex_q.rt == bus.id_rt_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if (!stall_i) begin
            if (flush_i || hazard) begin
                ex_q <= '0;
            end else begin
                ex_q <= ex_d;
            end
        end
    end

    // Bubbles carry rs/rt = 0, so the $0 guard also stops them forwarding.
    always_comb begin
        fwd_a = ex_q.rs_data;
        if (bus.exm_regwrite_i && (bus.exm_rd_i == ex_q.rs) && (ex_q.rs != 5'd0)) begin
            fwd_a = bus.exm_data_i;
        end else if (bus.wb_regwrite_i && (bus.wb_rd_i == ex_q.rs) && (ex_q.rs != 5'd0)) begin
            fwd_a = bus.wb_data_i;
        end
    end

    always_comb begin
        fwd_b = ex_q.rt_data;
        if (bus.exm_regwrite_i && (bus.exm_rd_i == ex_q.rt) && (ex_q.rt != 5'd0)) begin
            fwd_b = bus.exm_data_i;
        end else if (bus.wb_regwrite_i && (bus.wb_rd_i == ex_q.rt) && (ex_q.rt != 5'd0)) begin
            fwd_b = bus.wb_data_i;
        end
    end

    assign bus.data1_o     = fwd_a;
    assign bus.data2_o     = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign bus.mem_wdata_o = fwd_b;
    assign bus.alu_ctrl_o  = ex_q.alu_ctrl;
    assign bus.wreg_o      = ex_q.wreg;
    assign bus.regwrite_o  = ex_q.regwrite;
    assign bus.memread_o   = ex_q.memread;
    assign bus.memwrite_o  = ex_q.memwrite;
    assign bus.memtoreg_o  = ex_q.memtoreg;
    assign bus.hazard_o    = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [3:0]  e_alu;
        logic [4:0]  e_wreg;
        logic [31:0] e_d1, e_d2;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic [1:0] aluop, logic [5:0] funct,
                                logic alusrc, logic regdst, logic regwrite,
                                logic memread, logic memwrite, logic memtoreg,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rs_data, logic [31:0] rt_data, logic [31:0] imm,
                                logic [3:0] e_alu, logic [4:0] e_wreg,
                                logic [31:0] e_d1, logic [31:0] e_d2);
        vec_t v;
        v.aluop = aluop; v.funct = funct; v.alusrc = alusrc; v.regdst = regdst;
        v.regwrite = regwrite; v.memread = memread; v.memwrite = memwrite;
        v.memtoreg = memtoreg; v.rs = rs; v.rt = rt; v.rd = rd;
        v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm;
        v.e_alu = e_alu; v.e_wreg = e_wreg; v.e_d1 = e_d1; v.e_d2 = e_d2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_id(input vec_t v);
        bus.id_aluop_i    = v.aluop;
        bus.id_funct_i    = v.funct;
        bus.id_alusrc_i   = v.alusrc;
        bus.id_regdst_i   = v.regdst;
        bus.id_regwrite_i = v.regwrite;
        bus.id_memread_i  = v.memread;
        bus.id_memwrite_i = v.memwrite;
        bus.id_memtoreg_i = v.memtoreg;
        bus.id_rs_i       = v.rs;
        bus.id_rt_i       = v.rt;
        bus.id_rd_i       = v.rd;
        bus.id_rs_data_i  = v.rs_data;
        bus.id_rt_data_i  = v.rt_data;
        bus.id_imm_i      = v.imm;
    endtask

    task automatic clr_fwd();
        bus.exm_regwrite_i = 1'b0;
        bus.exm_rd_i       = 5'd0;
        bus.exm_data_i     = 32'd0;
        bus.wb_regwrite_i  = 1'b0;
        bus.wb_rd_i        = 5'd0;
        bus.wb_data_i      = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, " regwrite"}, 32'(bus.regwrite_o), 32'd0);
        chk({tag, " memread"},  32'(bus.memread_o),  32'd0);
        chk({tag, " memwrite"}, 32'(bus.memwrite_o), 32'd0);
        chk({tag, " memtoreg"}, 32'(bus.memtoreg_o), 32'd0);
        chk({tag, " alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'd0);
        chk({tag, " wreg"},     32'(bus.wreg_o),     32'd0);
        chk({tag, " data1"},    bus.data1_o,         32'd0);
        chk({tag, " data2"},    bus.data2_o,         32'd0);
        chk({tag, " hazard"},   32'(bus.hazard_o),   32'd0);
    endtask

    vec_t v;

    initial begin
        //           aluop  funct  src dst rw mr mw mt  rs  rt  rd  rs_data        rt_data        imm     alu      wreg  d1             d2
        vecs[0] = mk(2'b10, 6'h20, 0,  1,  1, 0, 0, 0,  1,  2,  3,  32'd100,       32'd200,       32'd0,  4'b0111, 5'd3, 32'd100,       32'd200);
        vecs[1] = mk(2'b10, 6'h18, 0,  1,  1, 0, 0, 0,  4,  5,  6,  32'h7,         32'h9,         32'd0,  4'b0100, 5'd6, 32'h7,         32'h9);
        vecs[2] = mk(2'b10, 6'h24, 0,  1,  1, 0, 0, 0,  1,  2,  7,  32'hf0f0,      32'h0ff0,      32'd0,  4'b0110, 5'd7, 32'hf0f0,      32'h0ff0);
        vecs[3] = mk(2'b10, 6'h25, 0,  1,  1, 0, 0, 0,  1,  2,  8,  32'h1,         32'h2,         32'd0,  4'b0101, 5'd8, 32'h1,         32'h2);
        vecs[4] = mk(2'b10, 6'h22, 0,  1,  1, 0, 0, 0,  3,  4,  9,  32'h30,        32'h4,         32'd0,  4'b0011, 5'd9, 32'h30,        32'h4);
        vecs[5] = mk(2'b10, 6'h3f, 0,  1,  1, 0, 0, 0,  3,  4, 10,  32'h5,         32'h6,         32'd0,  4'b0000, 5'd10, 32'h5,        32'h6);
        vecs[6] = mk(2'b11, 6'h00, 1,  0,  1, 0, 0, 0,  7,  8,  9,  32'd5,         32'd6,         32'h10, 4'b0001, 5'd8, 32'd5,         32'h10);
        vecs[7] = mk(2'b00, 6'h00, 1,  0,  1, 1, 0, 1,  1,  9,  0,  32'd1000,      32'd0,         32'd4,  4'b0111, 5'd9, 32'd1000,      32'd4);
        vecs[8] = mk(2'b00, 6'h00, 1,  0,  0, 0, 1, 0,  2, 10,  0,  32'd2000,      32'h55,        32'd8,  4'b0111, 5'd10, 32'd2000,     32'd8);
        vecs[9] = mk(2'b01, 6'h00, 0,  0,  0, 0, 0, 0, 11, 12,  0,  32'd3,         32'd3,         32'd0,  4'b0011, 5'd12, 32'd3,        32'd3);

        stall = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;

        // Reset with random inputs everywhere.
        bus.id_aluop_i     = 2'($urandom);
        bus.id_funct_i     = 6'($urandom);
        bus.id_alusrc_i    = 1'($urandom);
        bus.id_regdst_i    = 1'($urandom);
        bus.id_regwrite_i  = 1'b1;
        bus.id_memread_i   = 1'b1;
        bus.id_memwrite_i  = 1'($urandom);
        bus.id_memtoreg_i  = 1'($urandom);
        bus.id_rs_i        = 5'($urandom);
        bus.id_rt_i        = 5'($urandom);
        bus.id_rd_i        = 5'($urandom);
        bus.id_rs_data_i   = $urandom;
        bus.id_rt_data_i   = $urandom;
        bus.id_imm_i       = $urandom;
        bus.exm_regwrite_i = 1'($urandom);
        bus.exm_rd_i       = 5'($urandom);
        bus.exm_data_i     = $urandom;
        bus.wb_regwrite_i  = 1'($urandom);
        bus.wb_rd_i        = 5'($urandom);
        bus.wb_data_i      = $urandom;
        tick();
        tick();
        chk_bubble("reset");
        chk("reset mem_wdata", bus.mem_wdata_o, 32'd0);

        // First instruction after release.
        clr_fwd();
        rst = 1'b0;
        set_id(vecs[0]);
        tick();
        chk("post-reset alu_ctrl", 32'(bus.alu_ctrl_o), 32'b0111);
        chk("post-reset wreg",     32'(bus.wreg_o),     32'd3);

        // Decode / register sweep.
        for (int i = 0; i < 10; i++) begin
            set_id(vecs[i]);
            tick();
            chk($sformatf("vec%0d alu_ctrl", i),  32'(bus.alu_ctrl_o), 32'(vecs[i].e_alu));
            chk($sformatf("vec%0d wreg", i),      32'(bus.wreg_o),     32'(vecs[i].e_wreg));
            chk($sformatf("vec%0d data1", i),     bus.data1_o,         vecs[i].e_d1);
            chk($sformatf("vec%0d data2", i),     bus.data2_o,         vecs[i].e_d2);
            chk($sformatf("vec%0d mem_wdata", i), bus.mem_wdata_o,     vecs[i].rt_data);
            chk($sformatf("vec%0d regwrite", i),  32'(bus.regwrite_o), 32'(vecs[i].regwrite));
            chk($sformatf("vec%0d memread", i),   32'(bus.memread_o),  32'(vecs[i].memread));
            chk($sformatf("vec%0d memwrite", i),  32'(bus.memwrite_o), 32'(vecs[i].memwrite));
            chk($sformatf("vec%0d memtoreg", i),  32'(bus.memtoreg_o), 32'(vecs[i].memtoreg));
        end

        // Forwarding: add with rs=5 (0x11), rt=6 (0x22).
        v = mk(2'b10, 6'h20, 0, 1, 1, 0, 0, 0, 5, 6, 7, 32'h11, 32'h22, 32'd0, 4'b0111, 5'd7, 32'h11, 32'h22);
        set_id(v);
        tick();
        chk("fwd none data1", bus.data1_o, 32'h11);
        bus.exm_regwrite_i = 1'b1; bus.exm_rd_i = 5'd5; bus.exm_data_i = 32'hAA;
        bus.wb_regwrite_i  = 1'b1; bus.wb_rd_i  = 5'd5; bus.wb_data_i  = 32'hBB;
        #1;
        chk("fwd exm prio data1", bus.data1_o, 32'hAA);
        chk("fwd exm prio data2", bus.data2_o, 32'h22);
        bus.exm_regwrite_i = 1'b0;
        #1;
        chk("fwd wb data1", bus.data1_o, 32'hBB);
        bus.exm_regwrite_i = 1'b1; bus.exm_rd_i = 5'd5;
        bus.wb_rd_i = 5'd6; bus.wb_data_i = 32'hCC;
        #1;
        chk("fwd split data1", bus.data1_o, 32'hAA);
        chk("fwd wb data2", bus.data2_o, 32'hCC);
        chk("fwd wb mem_wdata", bus.mem_wdata_o, 32'hCC);
        clr_fwd();
        #1;
        chk("fwd off data1", bus.data1_o, 32'h11);

        // $0 never forwards.
        v = mk(2'b10, 6'h20, 0, 1, 1, 0, 0, 0, 0, 0, 7, 32'd0, 32'd0, 32'd0, 4'b0111, 5'd7, 32'd0, 32'd0);
        set_id(v);
        tick();
        bus.exm_regwrite_i = 1'b1; bus.exm_rd_i = 5'd0; bus.exm_data_i = 32'hFF;
        bus.wb_regwrite_i  = 1'b1; bus.wb_rd_i  = 5'd0; bus.wb_data_i  = 32'hEE;
        #1;
        chk("r0 data1", bus.data1_o, 32'd0);
        chk("r0 mem_wdata", bus.mem_wdata_o, 32'd0);
        clr_fwd();

        // Load-use: lw $4,0($1) then sub $5,$4,$2.
        v = mk(2'b00, 6'h00, 1, 0, 1, 1, 0, 1, 1, 4, 0, 32'd0, 32'd0, 32'd0, 4'b0111, 5'd4, 32'd0, 32'd0);
        set_id(v);
        tick();
        chk("lw memread", 32'(bus.memread_o), 32'd1);
        v = mk(2'b10, 6'h22, 0, 1, 1, 0, 0, 0, 4, 2, 5, 32'h0, 32'h2, 32'd0, 4'b0011, 5'd5, 32'h0, 32'h2);
        set_id(v);
        #1;
        chk("load-use hazard", 32'(bus.hazard_o), 32'd1);
        tick();
        chk_bubble("load-use bubble");
        bus.wb_regwrite_i = 1'b1; bus.wb_rd_i = 5'd4; bus.wb_data_i = 32'h1234;
        tick();
        chk("load-use dep alu_ctrl", 32'(bus.alu_ctrl_o), 32'b0011);
        chk("load-use dep wreg",     32'(bus.wreg_o),     32'd5);
        chk("load-use dep data1",    bus.data1_o,         32'h1234);
        chk("load-use dep data2",    bus.data2_o,         32'h2);
        chk("load-use hazard low",   32'(bus.hazard_o),   32'd0);
        clr_fwd();

        // Stall over flush, then flush alone.
        set_id(vecs[0]);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        set_id(vecs[6]);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("stall%0d alu_ctrl", c), 32'(bus.alu_ctrl_o), 32'b0111);
            chk($sformatf("stall%0d wreg", c),     32'(bus.wreg_o),     32'd3);
            chk($sformatf("stall%0d regwrite", c), 32'(bus.regwrite_o), 32'd1);
            chk($sformatf("stall%0d data1", c),    bus.data1_o,         32'd100);
            chk($sformatf("stall%0d data2", c),    bus.data2_o,         32'd200);
        end
        stall = 1'b0;
        tick();
        chk_bubble("flush bubble");
        flush = 1'b0;
        tick();
        chk("after flush alu_ctrl", 32'(bus.alu_ctrl_o), 32'b0001);
        chk("after flush data2",    bus.data2_o,         32'h10);

        // Flush coinciding with a hazard yields one bubble.
        set_id(vecs[7]);
        tick();
        v = mk(2'b10, 6'h24, 0, 1, 1, 0, 0, 0, 9, 2, 11, 32'h3, 32'h5, 32'd0, 4'b0110, 5'd11, 32'h3, 32'h5);
        set_id(v);
        flush = 1'b1;
        #1;
        chk("flush+hazard hazard", 32'(bus.hazard_o), 32'd1);
        tick();
        flush = 1'b0;
        chk_bubble("flush+hazard bubble");
        tick();
        chk("flush+hazard reload alu", 32'(bus.alu_ctrl_o), 32'b0110);
        chk("flush+hazard reload wreg", 32'(bus.wreg_o), 32'd11);

        // Reset mid-operation.
        set_id(vecs[1]);
        rst = 1'b1;
        tick();
        chk_bubble("mid reset");
        rst = 1'b0;
        tick();
        chk("mid reset reload alu", 32'(bus.alu_ctrl_o), 32'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
